// File: rtl/mtm_alu_rx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mtm_alu_rx_ctrl
// Description : Serial command receiver for the mtm ALU core. Deserializes
//               11-bit frames from sin, assembles {B,A} and the opmode,
//               validates length / CRC-4 / opmode and hands valid commands
//               to the core over a valid/ready handshake.
//               Optional macro MTM_ALU_RX_TIMEOUT_EN discards a partial
//               packet after TIMEOUT_CYCLES idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mtm_alu_rx_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [2:0]  op_out,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        err_valid,
  output logic [2:0]  err_flags,
  output logic        cmd_drop,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TYPE    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_STOP    = 2'd3
  } state_t;

  localparam logic [3:0] CNT_FULL   = 4'd8;
  localparam logic [3:0] CNT_POISON = 4'd9;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  bit_cnt;
  logic        frame_type;
  logic [7:0]  payload;
  logic [63:0] ba_sr;
  logic [3:0]  data_cnt;

  logic        frame_ok;
  logic        frame_bad;
  logic        data_done;
  logic        ctl_done;
  logic [2:0]  ctl_op;
  logic [3:0]  ctl_crc;
  logic [3:0]  crc_calc;
  logic        err_data;
  logic        err_crc;
  logic        err_op;
  logic        err_any;
  logic [2:0]  flags_nxt;
  logic        issue;
  logic        pending;
  logic        timeout_hit;

  // Serial CRC-4, x^4+x+1, init 0, MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // Bit FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Bit FSM next state and end-of-frame qualification.
  always_comb begin
    state_nxt = state;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state)
      S_IDLE:    if (!sin) state_nxt = S_TYPE;
      S_TYPE:    state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (bit_cnt == 3'd7) state_nxt = S_STOP;
      S_STOP: begin
        state_nxt = S_IDLE;
        frame_ok  = sin;
        frame_bad = !sin;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Frame type capture and MSB-first payload shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= 3'd0;
      frame_type <= 1'b0;
      payload    <= 8'd0;
    end else if (state == S_TYPE) begin
      bit_cnt    <= 3'd0;
      frame_type <= sin;
    end else if (state == S_PAYLOAD) begin
      bit_cnt <= bit_cnt + 3'd1;
      payload <= {payload[6:0], sin};
    end
  end

  assign data_done = frame_ok && !frame_type;
  assign ctl_done  = frame_ok &&  frame_type;
  assign ctl_op    = payload[6:4];
  assign ctl_crc   = payload[3:0];
  assign crc_calc  = crc4({ba_sr, 1'b1, ctl_op});

  // Prioritised packet checks: length, then CRC, then opmode.
  always_comb begin
    err_data  = (data_cnt != CNT_FULL);
    err_crc   = (crc_calc != ctl_crc);
    err_op    = !((ctl_op == 3'b000) || (ctl_op == 3'b001) ||
                  (ctl_op == 3'b100) || (ctl_op == 3'b101));
    flags_nxt = 3'b000;
    if (err_data)     flags_nxt = 3'b100;
    else if (err_crc) flags_nxt = 3'b010;
    else if (err_op)  flags_nxt = 3'b001;
    err_any   = ctl_done && (flags_nxt != 3'b000);
    issue     = ctl_done && (flags_nxt == 3'b000);
  end

`ifdef MTM_ALU_RX_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = (state == S_IDLE) && sin && (data_cnt != 4'd0) &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  // Idle-gap counter; any start bit or an empty packet restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt <= '0;
    else if ((state != S_IDLE) || !sin || (data_cnt == 4'd0) || timeout_hit)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Packet assembly: {B,A} shift register and saturating DATA frame count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ba_sr    <= 64'd0;
      data_cnt <= 4'd0;
    end else begin
      if (data_done) ba_sr <= {ba_sr[55:0], payload};
      if (frame_bad)
        data_cnt <= CNT_POISON;
      else if (ctl_done || timeout_hit)
        data_cnt <= 4'd0;
      else if (data_done && (data_cnt != CNT_POISON))
        data_cnt <= data_cnt + 4'd1;
    end
  end

  // A command still waiting for the core blocks a new issue.
  assign pending = op_valid && !op_ready;

  // Error strobe, drop pulse and command handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_flags <= 3'b000;
      cmd_drop  <= 1'b0;
      op_valid  <= 1'b0;
      a_out     <= 32'd0;
      b_out     <= 32'd0;
      op_out    <= 3'd0;
    end else begin
      err_valid <= err_any;
      err_flags <= err_any ? flags_nxt : 3'b000;
      cmd_drop  <= issue && pending;
      if (issue && !pending) begin
        op_valid <= 1'b1;
        a_out    <= ba_sr[31:0];
        b_out    <= ba_sr[63:32];
        op_out   <= ctl_op;
      end else if (op_valid && op_ready) begin
        op_valid <= 1'b0;
      end
    end
  end

  assign busy = (data_cnt != 4'd0) && (data_cnt <= CNT_FULL);

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_rx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mtm_alu_rx_ctrl
// Description : Self-checking bench for mtm_alu_rx_ctrl. A frame-level
//               packet model predicts every output each cycle; directed
//               packets plus literal spot checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mtm_alu_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic        op_ready = 1'b0;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [2:0]  op_out;
  logic        op_valid;
  logic        err_valid;
  logic [2:0]  err_flags;
  logic        cmd_drop;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;
  bit checking = 1'b0;

  // Frame hand-off from driver to model (driver writes, model reads).
  int          f_seq = 0;
  logic        f_type;
  logic [7:0]  f_pl;
  logic        f_ok;

  // Model state.
  int          last_seq = 0;
  int          m_cnt = 0;
  logic [63:0] m_ba = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [2:0]  m_op = '0;
  logic        m_valid = 1'b0;
  logic        m_err_v = 1'b0;
  logic [2:0]  m_err_f = '0;
  logic        m_drop = 1'b0;
  logic        m_was_pend;
  logic        m_issue;
  logic [2:0]  m_fop;

  mtm_alu_rx_ctrl #(.TIMEOUT_CYCLES(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .a_out     (a_out),
    .b_out     (b_out),
    .op_out    (op_out),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .err_valid (err_valid),
    .err_flags (err_flags),
    .cmd_drop  (cmd_drop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // CRC as polynomial remainder of {B,A,1,op}*x^4 modulo x^4+x+1.
  function automatic logic [3:0] crc_model(input logic [63:0] ba, input logic [2:0] op);
    logic [71:0] r;
    r = {ba, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame-level packet model, advanced at each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_ba = '0; m_a = '0; m_b = '0; m_op = '0;
      m_valid = 1'b0; m_err_v = 1'b0; m_err_f = '0; m_drop = 1'b0;
      last_seq = f_seq;
    end else begin
      m_was_pend = m_valid && !op_ready;
      if (m_valid && op_ready) m_valid = 1'b0;
      m_err_v = 1'b0; m_err_f = '0; m_drop = 1'b0; m_issue = 1'b0; m_fop = '0;
      if (f_seq != last_seq) begin
        last_seq = f_seq;
        if (!f_ok) begin
          m_cnt = 9;
        end else if (!f_type) begin
          m_ba = {m_ba[55:0], f_pl};
          if (m_cnt < 9) m_cnt++;
        end else begin
          m_fop = f_pl[6:4];
          if (m_cnt != 8)                            m_err_f = 3'b100;
          else if (f_pl[3:0] != crc_model(m_ba, m_fop)) m_err_f = 3'b010;
          else if (!(m_fop inside {3'b000, 3'b001, 3'b100, 3'b101})) m_err_f = 3'b001;
          else m_issue = 1'b1;
          m_err_v = (m_err_f != 3'b000);
          m_cnt = 0;
        end
      end
      if (m_issue) begin
        if (m_was_pend) m_drop = 1'b1;
        else begin
          m_a = m_ba[31:0]; m_b = m_ba[63:32]; m_op = m_fop; m_valid = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("op_valid",  op_valid,  m_valid);
      chk("err_valid", err_valid, m_err_v);
      chk("err_flags", err_flags, m_err_f);
      chk("cmd_drop",  cmd_drop,  m_drop);
      chk("busy",      busy,      (m_cnt >= 1 && m_cnt <= 8));
      if (m_valid || !rst_n) begin
        chk("a_out",  a_out,  m_a);
        chk("b_out",  b_out,  m_b);
        chk("op_out", op_out, m_op);
      end
    end
  end

  task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop_ok);
    logic [10:0] bits;
    bits = {1'b0, typ, pl, stop_ok};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      sin = bits[i];
      if (i == 0) begin
        f_type = typ; f_pl = pl; f_ok = stop_ok;
        f_seq++;
      end
    end
  endtask

  task automatic send_packet(input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic [3:0] crc, input int nd);
    logic [63:0] ba;
    ba = {b, a};
    for (int i = 0; i < nd; i++)
      send_frame(1'b0, (i < 8) ? ba[63 - 8*i -: 8] : 8'hA5, 1'b1);
    send_frame(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic good_packet(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    send_packet(a, b, op, crc_model({b, a}, op), 8);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sin = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ops [4];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b101;

    // Pin the CRC model with hand-derived remainders for A=B=0.
    chk("crc_model_and0", crc_model(64'd0, 3'b000), 4'hB);
    chk("crc_model_or0",  crc_model(64'd0, 3'b001), 4'h8);
    chk("crc_model_add0", crc_model(64'd0, 3'b100), 4'h7);
    chk("crc_model_sub0", crc_model(64'd0, 3'b101), 4'h4);

    // Reset state.
    repeat (2) @(negedge clk);
    checking = 1'b1;
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_a_out", a_out, 32'd0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Max/min operands, all ops, op_ready held high.
    op_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      good_packet(32'hFFFF_FFFF, 32'hFFFF_FFFF, ops[k]);
      idle(1);
      chk("max_op_out", op_out, ops[k]);
      chk("max_a_out", a_out, 32'hFFFF_FFFF);
      idle(1);
    end
    for (int k = 0; k < 4; k++) begin
      send_packet(32'd0, 32'd0, ops[k], crc_model(64'd0, ops[k]), 8);
      idle(1);
      chk("min_op_valid", op_valid, 1'b1);
      chk("min_op_out", op_out, ops[k]);
      chk("min_b_out", b_out, 32'd0);
      idle(1);
      chk("min_op_valid_fall", op_valid, 1'b0);
    end

    // Short packet, then a normal packet.
    send_packet(32'h1111_2222, 32'h3333_4444, 3'b100, 4'h0, 7);
    idle(1);
    chk("short_flags", err_flags, 3'b100);
    chk("short_op_valid", op_valid, 1'b0);
    good_packet(32'h0000_0005, 32'h0000_0007, 3'b101);
    idle(1);
    chk("after_short_a", a_out, 32'h0000_0005);

    // Long packet.
    send_packet(32'hDEAD_BEEF, 32'hCAFE_F00D, 3'b000, 4'h0, 9);
    idle(1);
    chk("long_flags", err_flags, 3'b100);

    // CRC error.
    send_packet(32'h1234_5678, 32'h9ABC_DEF0, 3'b100,
                crc_model({32'h9ABC_DEF0, 32'h1234_5678}, 3'b100) ^ 4'h1, 8);
    idle(1);
    chk("crc_flags", err_flags, 3'b010);
    chk("crc_op_valid", op_valid, 1'b0);

    // Bad opmode with correct CRC.
    good_packet(32'h1234_5678, 32'h9ABC_DEF0, 3'b011);
    idle(1);
    chk("badop_flags", err_flags, 3'b001);

    // Bad stop bit poisons the packet.
    send_frame(1'b0, 8'h12, 1'b1);
    send_frame(1'b0, 8'h34, 1'b0);
    send_packet(32'h0, 32'h0, 3'b000, 4'hB, 6);
    idle(1);
    chk("badstop_flags", err_flags, 3'b100);

    // Backpressure: two valid packets back to back.
    op_ready = 1'b0;
    good_packet(32'hAAAA_0001, 32'hBBBB_0001, 3'b100);
    good_packet(32'hAAAA_0002, 32'hBBBB_0002, 3'b001);
    idle(1);
    chk("bp_drop", cmd_drop, 1'b1);
    chk("bp_a_held", a_out, 32'hAAAA_0001);
    chk("bp_op_held", op_out, 3'b100);
    idle(3);
    op_ready = 1'b1;
    idle(2);

    // Reset during DATA frame 5 with a command pending.
    op_ready = 1'b0;
    good_packet(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b000);
    for (int i = 0; i < 4; i++) send_frame(1'b0, 8'h5A, 1'b1);
    @(negedge clk); sin = 1'b0;
    @(negedge clk); sin = 1'b0;
    @(negedge clk); sin = 1'b1;
    @(negedge clk); sin = 1'b0;
    #1 rst_n = 1'b0; sin = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_op_valid", op_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_a_out", a_out, 32'd0);
    rst_n = 1'b1;
    op_ready = 1'b1;
    idle(2);
    good_packet(32'h1234_5678, 32'h9ABC_DEF0, 3'b100);
    idle(1);
    chk("post_rst_a", a_out, 32'h1234_5678);
    chk("post_rst_b", b_out, 32'h9ABC_DEF0);
    idle(3);

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
